// File: rtl/phase_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : phase_sweep_gen
//  Description : Programmable frequency-sweep generator. Emits DDS
//                phase-increment words on an AXI4-Stream master, either as a
//                ramp that wraps back to start or as a triangle (up then
//                down). Start/step/stop/dwell are latched at the start of
//                every sweep. tlast marks the final beat of each sweep.
//                Optional macro SWEEP_CNT_EN adds a completed-sweep counter
//                output (sweep_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_sweep_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 32
`ifdef SWEEP_CNT_EN
    ,
    parameter int SWEEP_CNT_WIDTH = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cfg_mode,
    input  logic [PHASE_WIDTH-1:0] cfg_start,
    input  logic [PHASE_WIDTH-1:0] cfg_step,
    input  logic [PHASE_WIDTH-1:0] cfg_stop,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    output logic                   m_axis_phase_tvalid,
    input  logic                   m_axis_phase_tready,
    output logic [PHASE_WIDTH-1:0] m_axis_phase_tdata,
    output logic                   m_axis_phase_tlast,
    output logic                   busy
`ifdef SWEEP_CNT_EN
    ,
    output logic [SWEEP_CNT_WIDTH-1:0] sweep_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SEND  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    state_t                 r_state;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic [PHASE_WIDTH-1:0] r_cur;
    logic                   r_dir;
    logic                   r_sweep_done;
    logic [DWELL_WIDTH-1:0] r_cnt;

    // Shadow copy of the configuration, frozen for the duration of a sweep
    logic                   r_sh_mode;
    logic [PHASE_WIDTH-1:0] r_sh_start;
    logic [PHASE_WIDTH-1:0] r_sh_step;
    logic [PHASE_WIDTH-1:0] r_sh_stop;
    logic [DWELL_WIDTH-1:0] r_sh_dwell;

`ifdef SWEEP_CNT_EN
    logic [SWEEP_CNT_WIDTH-1:0] r_sweep_cnt;
`endif

    // An inverted range collapses to a single-point sweep at start
    logic [PHASE_WIDTH-1:0] w_load_stop;
    assign w_load_stop = (cfg_start > cfg_stop) ? cfg_start : cfg_stop;

    // Operands for the step evaluation: live config while loading, else shadow
    logic                   w_src_mode;
    logic                   w_src_dir;
    logic [PHASE_WIDTH-1:0] w_src_cur;
    logic [PHASE_WIDTH-1:0] w_src_start;
    logic [PHASE_WIDTH-1:0] w_src_step;
    logic [PHASE_WIDTH-1:0] w_src_stop;

    // Result of evaluating the beat held in w_src_cur
    logic [PHASE_WIDTH:0]   w_sum;
    logic [PHASE_WIDTH:0]   w_lower;
    logic [PHASE_WIDTH-1:0] w_diff;
    logic [PHASE_WIDTH-1:0] w_next;
    logic                   w_next_dir;
    logic                   w_last;

    // Select operand source so one evaluator serves LOAD, SEND and DWELL
    always_comb begin
        w_src_mode  = r_sh_mode;
        w_src_dir   = r_dir;
        w_src_cur   = r_cur;
        w_src_start = r_sh_start;
        w_src_step  = r_sh_step;
        w_src_stop  = r_sh_stop;
        if (r_state == S_LOAD) begin
            w_src_mode  = cfg_mode;
            w_src_dir   = c_DIR_UP;
            w_src_cur   = cfg_start;
            w_src_start = cfg_start;
            w_src_step  = cfg_step;
            w_src_stop  = w_load_stop;
        end
    end

    // Next-value and tlast rules, evaluated one bit wider to catch overflow
    always_comb begin
        w_sum      = {1'b0, w_src_cur} + {1'b0, w_src_step};
        w_lower    = {1'b0, w_src_start} + {1'b0, w_src_step};
        w_diff     = w_src_cur - w_src_step;
        w_next     = w_sum[PHASE_WIDTH-1:0];
        w_next_dir = w_src_dir;
        w_last     = 1'b0;
        if (w_src_step == '0) begin
            // Zero step: every beat is start and closes a sweep
            w_last     = 1'b1;
            w_next     = w_src_start;
            w_next_dir = c_DIR_UP;
        end else if (!w_src_mode) begin
            if (w_sum > {1'b0, w_src_stop}) begin
                w_last = 1'b1;
                w_next = w_src_start;
            end
        end else if (w_src_dir == c_DIR_UP) begin
            if (w_sum > {1'b0, w_src_stop}) begin
                if ({1'b0, w_src_cur} < w_lower) begin
                    // No room to come back down: single-beat triangle
                    w_last     = 1'b1;
                    w_next     = w_src_start;
                    w_next_dir = c_DIR_UP;
                end else begin
                    w_next     = w_diff;
                    w_next_dir = c_DIR_DOWN;
                end
            end
        end else begin
            if (({1'b0, w_src_cur} < w_lower) || (w_src_cur == w_src_start)) begin
                w_last     = 1'b1;
                w_next     = w_src_start;
                w_next_dir = c_DIR_UP;
            end else begin
                w_next = w_diff;
            end
        end
    end

    // Sweep sequencer: state, shadow config, beat registers and dwell timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_cur        <= '0;
            r_dir        <= c_DIR_UP;
            r_sweep_done <= 1'b0;
            r_cnt        <= '0;
            r_sh_mode    <= 1'b0;
            r_sh_start   <= '0;
            r_sh_step    <= '0;
            r_sh_stop    <= '0;
            r_sh_dwell   <= '0;
`ifdef SWEEP_CNT_EN
            r_sweep_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    if (enable) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_sh_mode    <= cfg_mode;
                    r_sh_start   <= cfg_start;
                    r_sh_step    <= cfg_step;
                    r_sh_stop    <= w_load_stop;
                    r_sh_dwell   <= cfg_dwell;
                    r_cur        <= cfg_start;
                    r_dir        <= c_DIR_UP;
                    r_sweep_done <= 1'b0;
                    r_last       <= w_last;
                    r_valid      <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    // Beat is held until accepted, even if enable drops
                    if (m_axis_phase_tready) begin
                        r_valid      <= 1'b0;
                        r_last       <= 1'b0;
                        r_cur        <= w_next;
                        r_dir        <= w_next_dir;
                        r_sweep_done <= r_last;
                        r_cnt        <= '0;
                        r_state      <= S_DWELL;
`ifdef SWEEP_CNT_EN
                        if (r_last) begin
                            r_sweep_cnt <= r_sweep_cnt + SWEEP_CNT_WIDTH'(1);
                        end
`endif
                    end
                end
                S_DWELL: begin
                    if (r_cnt == r_sh_dwell) begin
                        if (!enable) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else if (r_sweep_done) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_valid <= 1'b1;
                            r_last  <= w_last;
                            r_state <= S_SEND;
                        end
                    end else begin
                        r_cnt <= r_cnt + DWELL_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_phase_tvalid = r_valid;
    assign m_axis_phase_tlast  = r_last;
    assign m_axis_phase_tdata  = r_cur;
    assign busy                = r_busy;
`ifdef SWEEP_CNT_EN
    assign sweep_count         = r_sweep_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phase_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_sweep_gen
//  Description : Self-checking bench for phase_sweep_gen. Accepted beats are
//                compared with a closed-form sweep model (beat n of a run is
//                start + j*step, j following a ramp or triangle index).
//                Define SWEEP_CNT_EN to also check sweep_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_sweep_gen;

    localparam int PW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          cfg_mode;
    logic [PW-1:0] cfg_start;
    logic [PW-1:0] cfg_step;
    logic [PW-1:0] cfg_stop;
    logic [DW-1:0] cfg_dwell;
    logic          tvalid;
    logic          tready;
    logic [PW-1:0] tdata;
    logic          tlast;
    logic          busy;
`ifdef SWEEP_CNT_EN
    logic [15:0]   sweep_count;
`endif

    phase_sweep_gen #(
        .PHASE_WIDTH(PW),
        .DWELL_WIDTH(DW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .cfg_mode            (cfg_mode),
        .cfg_start           (cfg_start),
        .cfg_step            (cfg_step),
        .cfg_stop            (cfg_stop),
        .cfg_dwell           (cfg_dwell),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tdata  (tdata),
        .m_axis_phase_tlast  (tlast),
        .busy                (busy)
`ifdef SWEEP_CNT_EN
        ,
        .sweep_count         (sweep_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_start;
    logic [63:0] m_step;
    logic [63:0] m_dwell;
    int          m_k;
    int          m_len;

    function automatic void model_set(input bit mode, input logic [31:0] st, input logic [31:0] sp,
                                      input logic [31:0] so, input logic [31:0] dw);
        logic [63:0] eff;
        m_start = 64'(st);
        m_step  = 64'(sp);
        m_dwell = 64'(dw);
        eff     = (so < st) ? 64'(st) : 64'(so);
        m_k     = (sp == 0) ? 0 : int'((eff - m_start) / m_step);
        m_len   = mode ? ((m_k == 0) ? 1 : 2 * m_k + 1) : m_k + 1;
    endfunction

    function automatic logic [63:0] model_val(input int n);
        int pos;
        int j;
        pos = n % m_len;
        j   = (pos <= m_k) ? pos : 2 * m_k - pos;
        return m_start + 64'(j) * m_step;
    endfunction

    function automatic logic model_last(input int n);
        return (n % m_len) == (m_len - 1);
    endfunction

    // ---------------- monitor ----------------
    int          cyc     = 0;
    int          last_hs = 0;
    int          beat_n  = 0;
    bit          gap_chk = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;
    int          exp_sc  = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_stall = 0;
                exp_sc     = 0;
            end else begin
`ifdef SWEEP_CNT_EN
                check_val("sweep_count", 64'(sweep_count), 64'(exp_sc[15:0]));
`endif
                if (prev_stall) begin
                    check_val("hold_valid", 64'(tvalid), 64'd1);
                    check_val("hold_data", 64'(tdata), 64'(prev_data));
                    check_val("hold_last", 64'(tlast), 64'(prev_last));
                end
                if (tvalid && tready) begin
                    check_val("beat_data", 64'(tdata), model_val(beat_n));
                    check_val("beat_last", 64'(tlast), 64'(model_last(beat_n)));
                    if (gap_chk && beat_n > 0 && !model_last(beat_n - 1))
                        check_val("beat_gap", 64'(cyc - last_hs), m_dwell + 64'd2);
                    if (model_last(beat_n)) exp_sc++;
                    last_hs = cyc;
                    beat_n++;
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_last  = tlast;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run(input bit mode, input logic [31:0] st, input logic [31:0] sp,
                             input logic [31:0] so, input logic [31:0] dw, input bit rdy0);
        cfg_mode  = mode;
        cfg_start = st;
        cfg_step  = sp;
        cfg_stop  = so;
        cfg_dwell = dw;
        model_set(mode, st, sp, so, dw);
        beat_n  = 0;
        gap_chk = 0;
        tready  = rdy0;
        enable  = 1'b1;
        @(posedge clk); #1;
        check_val("first_not_yet", 64'(tvalid), 64'd0);
        check_val("busy_load", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_val("first_valid", 64'(tvalid), 64'd1);
        check_val("first_data", 64'(tdata), 64'(st));
    endtask

    task automatic wait_beats(input int nb, input bit rr);
        int guard;
        guard = 0;
        while (beat_n < nb && guard < 5000) begin
            tready = rr ? (($urandom % 3) != 0) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        if (beat_n < nb) check_val("beat_budget", 64'(beat_n), 64'(nb));
    endtask

    task automatic stop_run();
        int guard;
        enable = 1'b0;
        tready = 1'b1;
        guard  = 0;
        while (busy && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check_val("stop_busy", 64'(busy), 64'd0);
        check_val("stop_valid", 64'(tvalid), 64'd0);
    endtask

    // Global bound on run length
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        reset     = 1'b1;
        enable    = 1'b0;
        tready    = 1'b1;
        cfg_mode  = 1'b0;
        cfg_start = '0;
        cfg_step  = '0;
        cfg_stop  = '0;
        cfg_dwell = '0;
        model_set(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #3;
        check_val("rst_valid", 64'(tvalid), 64'd0);
        check_val("rst_last", 64'(tlast), 64'd0);
        check_val("rst_data", 64'(tdata), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        #20 reset = 1'b0;
        @(posedge clk); #1;
        check_val("idle_busy", 64'(busy), 64'd0);

        // Ramp, five beats, steady ready, two full sweeps plus change
        start_run(1'b0, 32'h0051EB85, 32'h0051EB85, 32'h01999999, 32'd3, 1'b1);
        gap_chk = 1;
        wait_beats(12, 1'b0);
        stop_run();

        // Triangle 10,20,30,20,10
        start_run(1'b1, 32'd10, 32'd10, 32'd35, 32'd1, 1'b1);
        gap_chk = 1;
        wait_beats(11, 1'b0);
        stop_run();

        // Backpressure on beat 2 of the ramp
        start_run(1'b0, 32'h0051EB85, 32'h0051EB85, 32'h01999999, 32'd3, 1'b1);
        guard = 0;
        while (beat_n < 1 && guard < 100) begin @(posedge clk); #1; guard++; end
        tready = 1'b0;
        guard  = 0;
        while (!tvalid && guard < 100) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 7; i++) begin
            check_val("bp_valid", 64'(tvalid), 64'd1);
            check_val("bp_data", 64'(tdata), 64'h00A3D70A);
            @(posedge clk); #1;
        end
        check_val("bp_count", 64'(beat_n), 64'd1);
        wait_beats(7, 1'b0);
        stop_run();

        // Degenerate: zero step, ramp and triangle
        start_run(1'b0, 32'h100, 32'h0, 32'h800, 32'd0, 1'b1);
        gap_chk = 1;
        wait_beats(4, 1'b0);
        stop_run();
        start_run(1'b1, 32'h100, 32'h0, 32'h800, 32'd2, 1'b1);
        wait_beats(3, 1'b0);
        stop_run();

        // Degenerate: start above stop
        start_run(1'b0, 32'h200, 32'h10, 32'h100, 32'd1, 1'b1);
        wait_beats(4, 1'b0);
        stop_run();

        // Top of range: sum exceeds PHASE_WIDTH bits
        start_run(1'b0, 32'hFFFFFF00, 32'h80, 32'hFFFFFFFF, 32'd0, 1'b1);
        wait_beats(5, 1'b0);
        stop_run();
        start_run(1'b1, 32'hFFFFFF00, 32'h80, 32'hFFFFFFFF, 32'd0, 1'b1);
        wait_beats(7, 1'b1);
        stop_run();

        // Enable drops while a beat is stalled
        start_run(1'b0, 32'h1000, 32'h100, 32'h2000, 32'd2, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("drop_hold", 64'(tvalid), 64'd1);
        end
        tready = 1'b1;
        @(posedge clk); #1;
        check_val("drop_accept", 64'(tvalid), 64'd0);
        check_val("drop_busy_dwell", 64'(busy), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("drop_busy_dwell2", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check_val("drop_idle", 64'(busy), 64'd0);
        check_val("drop_beats", 64'(beat_n), 64'd1);
        start_run(1'b0, 32'h3000, 32'h100, 32'h3400, 32'd1, 1'b1);
        wait_beats(6, 1'b0);
        stop_run();

        // Randomised configurations
        for (int r = 0; r < 8; r++) begin
            logic [31:0] st;
            logic [31:0] sp;
            logic [31:0] so;
            int          k;
            bit          mode;
            bit          rr;
            st   = $urandom_range(0, 32'h7FFFFFFF);
            sp   = $urandom_range(1, 32'h00100000);
            k    = $urandom_range(0, 6);
            so   = st + sp * 32'(k) + 32'($urandom_range(0, 32'(sp - 1)));
            mode = 1'($urandom % 2);
            rr   = 1'(r % 2);
            start_run(mode, st, sp, so, 32'($urandom_range(0, 3)), 1'b1);
            gap_chk = !rr;
            wait_beats(2 * m_len + 2, rr);
            stop_run();
        end

        // Asynchronous reset in the middle of a stalled beat
        start_run(1'b0, 32'h5000, 32'h100, 32'h6000, 32'd1, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_val("arst_valid", 64'(tvalid), 64'd0);
        check_val("arst_last", 64'(tlast), 64'd0);
        check_val("arst_data", 64'(tdata), 64'd0);
        check_val("arst_busy", 64'(busy), 64'd0);
        enable = 1'b0;
        #10 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("post_rst_busy", 64'(busy), 64'd0);
            check_val("post_rst_valid", 64'(tvalid), 64'd0);
        end
        tready = 1'b1;
        start_run(1'b1, 32'd10, 32'd10, 32'd35, 32'd0, 1'b1);
        wait_beats(5, 1'b0);
        stop_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
